// File: rtl/bus_arbiter_config.sv
// Types and sizing for the L2-to-L3 round-robin arbiter.
package bus_arbiter_config;
  import main_memory_config::*;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    ARB_RD,
    ARB_WR
  } arb_op_t;

  localparam int NUM_REQUESTERS     = 4;
  localparam int ARB_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/main_memory_config.sv
// Downstream memory geometry shared by every agent on the L3 side.
package main_memory_config;
  localparam int MAIN_MEMORY_ADDRESS_WIDTH = 32;
  localparam int MAIN_MEMORY_DATA_WIDTH    = 128;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first candidate at or after ptr_i.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  cand_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && cand_i[(int'(ptr_i) + k) % N]) begin
        any_o = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
        onehot_o[(int'(ptr_i) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/l2_bus_arbiter.sv
// Shares the single L3/main-memory port among the private L2 caches,
// one latched line transaction at a time, round-robin fair.
module l2_bus_arbiter
  import main_memory_config::*;
  import bus_arbiter_config::*;
#(
  parameter int NUM_REQ        = NUM_REQUESTERS,
  parameter int AW             = MAIN_MEMORY_ADDRESS_WIDTH,
  parameter int LW             = MAIN_MEMORY_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_address,
  input  logic [NUM_REQ*LW-1:0] req_write_data,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  req_error,
  output logic [LW-1:0]         req_read_data,
  output logic                  main_memory_read_request,
  output logic                  main_memory_write_request,
  output logic [AW-1:0]         main_memory_address,
  output logic [LW-1:0]         main_memory_write_data,
  input  logic [LW-1:0]         main_memory_read_data,
  input  logic                  main_memory_ready
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t         state_q, state_d;
  arb_op_t            op_q, op_d;
  logic [IW-1:0]      id_q, id_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [LW-1:0]      wdata_q, wdata_d;
  logic [LW-1:0]      rdata_q, rdata_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .cand_i   ((req_read | req_write) & ~mask_q),
    .ptr_i    (ptr_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    mask_d  = '0;
    grant_d = grant_q;
    ready_d = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          state_d = ARB_ISSUE;
          id_d    = win_idx;
          // write-back must precede a refill of the same line
          op_d    = req_write[win_idx] ? ARB_WR : ARB_RD;
          addr_d  = req_address[int'(win_idx)*AW +: AW];
          wdata_d = req_write_data[int'(win_idx)*LW +: LW];
          grant_d = win_oh;
          cnt_d   = '0;
          wr_d    = req_write[win_idx];
          rd_d    = !req_write[win_idx];
        end
      end
      ARB_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (main_memory_ready) begin
          state_d = ARB_RESP;
          ready_d = grant_q;
          err_d   = 1'b0;
          rdata_d = (op_q == ARB_RD) ? main_memory_read_data : '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ARB_RESP;
          ready_d = grant_q;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          rd_d = (op_q == ARB_RD);
          wr_d = (op_q == ARB_WR);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        ptr_d   = IW'((int'(id_q) + 1) % NUM_REQ);
        // owner is still dropping its level request this cycle
        mask_d  = grant_q;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      op_q    <= ARB_RD;
      id_q    <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign req_grant                 = grant_q;
  assign req_ready                 = ready_q;
  assign req_error                 = err_q;
  assign req_read_data             = rdata_q;
  assign main_memory_read_request  = rd_q;
  assign main_memory_write_request = wr_q;
  assign main_memory_address       = addr_q;
  assign main_memory_write_data    = wdata_q;
endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Directed checks of l2_bus_arbiter: fairness, ordering,
// timeout, reset abort and stale-input immunity.
module tb_l2_bus_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_read, req_write;
  logic [127:0] req_address;
  logic [511:0] req_write_data;
  logic [3:0]   req_grant, req_ready;
  logic         req_error;
  logic [127:0] req_read_data;
  logic         mm_rd, mm_wr;
  logic [31:0]  mm_addr;
  logic [127:0] mm_wdata, mm_rdata;
  logic         mm_ready;

  int n_chk = 0;
  int n_err = 0;

  l2_bus_arbiter dut (
    .clk                       (clk),
    .reset                     (reset),
    .req_read                  (req_read),
    .req_write                 (req_write),
    .req_address               (req_address),
    .req_write_data            (req_write_data),
    .req_grant                 (req_grant),
    .req_ready                 (req_ready),
    .req_error                 (req_error),
    .req_read_data             (req_read_data),
    .main_memory_read_request  (mm_rd),
    .main_memory_write_request (mm_wr),
    .main_memory_address       (mm_addr),
    .main_memory_write_data    (mm_wdata),
    .main_memory_read_data     (mm_rdata),
    .main_memory_ready         (mm_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    req_read       = '0;
    req_write      = '0;
    req_address    = '0;
    req_write_data = '0;
    mm_rdata       = '0;
    mm_ready       = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // From an IDLE negedge with requests applied: grant, hold, respond.
  task automatic run_txn(input logic [3:0] g, input bit wr,
                         input int wait_c, input logic [127:0] d,
                         input logic [31:0] a);
    tick();
    chk("grant", 128'(req_grant), 128'(g));
    chk("mm_rd", 128'(mm_rd), 128'(!wr));
    chk("mm_wr", 128'(mm_wr), 128'(wr));
    chk("mm_addr", 128'(mm_addr), 128'(a));
    repeat (wait_c) begin
      tick();
      chk("hold_req", 128'(mm_rd | mm_wr), 128'(1));
      chk("no_early_ready", 128'(req_ready), 128'(0));
    end
    mm_ready = 1'b1;
    mm_rdata = d;
    tick();
    mm_ready = 1'b0;
    chk("ready", 128'(req_ready), 128'(g));
    chk("resp_grant", 128'(req_grant), 128'(g));
    chk("resp_err", 128'(req_error), 128'(0));
    chk("req_dropped", 128'(mm_rd | mm_wr), 128'(0));
    if (!wr) chk("rdata", req_read_data, d);
    tick();
    chk("ready_pulse", 128'(req_ready), 128'(0));
    chk("grant_clr", 128'(req_grant), 128'(0));
  endtask

  initial begin
    reset          = 1'b1;
    req_read       = '0;
    req_write      = '0;
    req_address    = '0;
    req_write_data = '0;
    mm_rdata       = '0;
    mm_ready       = 1'b0;
    @(negedge clk);
    chk("rst_grant", 128'(req_grant), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_err", 128'(req_error), 128'(0));
    chk("rst_mmreq", 128'({mm_rd, mm_wr}), 128'(0));
    chk("rst_addr", 128'(mm_addr), 128'(0));
    chk("rst_rdata", req_read_data, 128'(0));
    reset = 1'b0;

    // single read, ready on the 4th ISSUE cycle
    req_read = 4'b0001;
    req_address[31:0] = 32'hA000_0000;
    run_txn(4'b0001, 1'b0, 3, 128'hDEADBEEF, 32'hA000_0000);
    req_read = '0;

    // contention: full round-robin sweep and wrap
    do_reset();
    req_read = 4'b1111;
    for (int i = 0; i < 4; i++)
      req_address[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 5; i++)
      run_txn(4'(1 << (i % 4)), 1'b0, i % 2, 128'h100 + 128'(i),
              32'h1000_0000 + 32'(i % 4));
    req_read = '0;

    // same requester read+write: write-back first
    do_reset();
    req_read[2]  = 1'b1;
    req_write[2] = 1'b1;
    req_address[64 +: 32]     = 32'h0000_2040;
    req_write_data[256 +: 128] = 128'h00000000DEADBEEF;
    tick();
    chk("wb_first", 128'(mm_wr), 128'(1));
    chk("wb_data", mm_wdata, 128'h00000000DEADBEEF);
    chk("wb_grant", 128'(req_grant), 128'(4'b0100));
    mm_ready = 1'b1;
    tick();
    mm_ready = 1'b0;
    chk("wb_ready", 128'(req_ready), 128'(4'b0100));
    tick();
    req_write[2] = 1'b0;
    tick();
    chk("mask_hold", 128'(req_grant), 128'(0));
    run_txn(4'b0100, 1'b0, 1, 128'hCAFE, 32'h0000_2040);
    req_read = '0;

    // timeout after 255 ISSUE cycles
    do_reset();
    req_write[1] = 1'b1;
    req_address[32 +: 32] = 32'h0000_5000;
    tick();
    for (int i = 0; i < 255; i++) begin
      if (i == 0 || i == 254) begin
        chk("to_wr_held", 128'(mm_wr), 128'(1));
        chk("to_no_ready", 128'(req_ready), 128'(0));
      end
      tick();
    end
    chk("to_ready", 128'(req_ready), 128'(4'b0010));
    chk("to_err", 128'(req_error), 128'(1));
    chk("to_rdata", req_read_data, 128'(0));
    chk("to_wr_drop", 128'(mm_wr), 128'(0));
    req_write = '0;
    tick();
    chk("to_err_clr", 128'(req_error), 128'(0));
    req_read = 4'b1111;
    run_txn(4'b0100, 1'b0, 0, 128'h77, 32'h0000_0000);
    req_read = '0;

    // reset mid-ISSUE aborts; pointer returns to 0
    req_write[1] = 1'b1;
    req_address[32 +: 32] = 32'h0000_6000;
    tick();
    chk("ab_wr", 128'(mm_wr), 128'(1));
    reset = 1'b1;
    #1;
    chk("ab_wr_drop", 128'(mm_wr), 128'(0));
    chk("ab_grant", 128'(req_grant), 128'(0));
    chk("ab_addr", 128'(mm_addr), 128'(0));
    mm_ready = 1'b1;
    tick();
    chk("ab_no_ready", 128'(req_ready), 128'(0));
    mm_ready  = 1'b0;
    reset     = 1'b0;
    req_write = '0;
    req_read  = 4'b1111;
    run_txn(4'b0001, 1'b0, 0, 128'h55, 32'h0000_0000);
    req_read = '0;

    // stale ready in IDLE, address change after latch
    do_reset();
    mm_ready = 1'b1;
    tick();
    chk("st_grant", 128'(req_grant), 128'(0));
    chk("st_ready", 128'(req_ready), 128'(0));
    mm_ready = 1'b0;
    req_read[3] = 1'b1;
    req_address[96 +: 32] = 32'h3000_0000;
    tick();
    chk("st_g", 128'(req_grant), 128'(4'b1000));
    req_address[96 +: 32] = 32'hFFFF_0000;
    req_read = '0;
    tick();
    chk("st_addr", 128'(mm_addr), 128'(32'h3000_0000));
    chk("st_rd_held", 128'(mm_rd), 128'(1));
    mm_ready = 1'b1;
    mm_rdata = 128'h1234;
    tick();
    mm_ready = 1'b0;
    chk("st_ready2", 128'(req_ready), 128'(4'b1000));
    chk("st_rdata", req_read_data, 128'h1234);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
